// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - 8N1 UART receiver, command-frame decoder, optional echo transmitter
// Optional echo transmitter is built when UART_CMD_ECHO_EN is defined.
module uart_cmd_decoder #(
  parameter int SYS_CLK   = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BIT  = 32,
  parameter int PACK_NUM  = 4,
  parameter int FREQ_NUM  = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                rx_i,
  output logic                tx_o,
  output logic [DATA_BIT-1:0] output_pattern_o,
  output logic [DATA_BIT-1:0] freq_pattern_o,
  output logic [7:0]          sel_out_o,
  output logic [1:0]          mode_o,
  output logic                enable_o,
  output logic                stop_o,
  output logic [7:0]          slow_period_o,
  output logic [7:0]          fast_period_o,
  output logic [7:0]          repeat_o,
  output logic [7:0]          cmd_o,
  output logic                done_tick_o
);

  localparam int CLKS_PER_BIT = SYS_CLK / BAUD_RATE;
  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int BC_W  = $clog2(PACK_NUM + 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [7:0] CMD_FREQ   = 8'h01;
  localparam logic [7:0] CMD_PERIOD = 8'h02;
  localparam logic [7:0] CMD_DATA   = 8'h03;
  localparam logic [7:0] CMD_CTRL   = 8'h04;
  localparam logic [7:0] CMD_REPEAT = 8'h05;

  // ---------------- UART receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_done;
  logic             rx_fall;

  assign rx_fall = rx_prev_q & ~rx_sync_q;

  // Two-flop synchroniser plus one delay stage for falling-edge detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receiver state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // Receiver next state: mid-start recheck, then one sample per bit period
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          rx_done    = rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- Command-frame decoder ----------------
  typedef enum logic [1:0] {D_IDLE, D_CHAN, D_PAYLOAD, D_COMMIT} dec_state_t;

  dec_state_t          dec_state_q, dec_state_d;
  logic [7:0]          cmd_sh_q, cmd_sh_d, chan_sh_q, chan_sh_d;
  logic [DATA_BIT-1:0] data_sh_q, data_sh_d;
  logic [BC_W-1:0]     byte_cnt_q, byte_cnt_d, byte_last;
  logic [DATA_BIT-1:0] out_pat_q, out_pat_d, freq_pat_q, freq_pat_d;
  logic [7:0]          sel_q, sel_d, slow_q, slow_d, fast_q, fast_d, rep_q, rep_d, cmd_q, cmd_d;
  logic [1:0]          mode_q, mode_d;
  logic                en_q, en_d, stop_q, stop_d;

  // Decoder state, shadow and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dec_state_q <= D_IDLE;
      cmd_sh_q    <= '0;
      chan_sh_q   <= '0;
      data_sh_q   <= '0;
      byte_cnt_q  <= '0;
      out_pat_q   <= '0;
      freq_pat_q  <= '0;
      sel_q       <= '0;
      slow_q      <= '0;
      fast_q      <= '0;
      rep_q       <= '0;
      cmd_q       <= '0;
      mode_q      <= '0;
      en_q        <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      dec_state_q <= dec_state_d;
      cmd_sh_q    <= cmd_sh_d;
      chan_sh_q   <= chan_sh_d;
      data_sh_q   <= data_sh_d;
      byte_cnt_q  <= byte_cnt_d;
      out_pat_q   <= out_pat_d;
      freq_pat_q  <= freq_pat_d;
      sel_q       <= sel_d;
      slow_q      <= slow_d;
      fast_q      <= fast_d;
      rep_q       <= rep_d;
      cmd_q       <= cmd_d;
      mode_q      <= mode_d;
      en_q        <= en_d;
      stop_q      <= stop_d;
    end
  end

  // Payload length of the latched command, as the index of its final byte
  always_comb begin
    byte_last = '0;
    case (cmd_sh_q)
      CMD_FREQ, CMD_DATA: byte_last = BC_W'(PACK_NUM - 1);
      CMD_PERIOD:         byte_last = BC_W'(FREQ_NUM - 1);
      default:            byte_last = '0;
    endcase
  end

  // Decoder next state; payload bytes shift in from the top so the first lands lowest
  always_comb begin
    dec_state_d = dec_state_q;
    cmd_sh_d    = cmd_sh_q;
    chan_sh_d   = chan_sh_q;
    data_sh_d   = data_sh_q;
    byte_cnt_d  = byte_cnt_q;
    out_pat_d   = out_pat_q;
    freq_pat_d  = freq_pat_q;
    sel_d       = sel_q;
    slow_d      = slow_q;
    fast_d      = fast_q;
    rep_d       = rep_q;
    cmd_d       = cmd_q;
    mode_d      = mode_q;
    en_d        = en_q;
    stop_d      = stop_q;
    done_tick_o = 1'b0;
    case (dec_state_q)
      D_IDLE: begin
        if (rx_done) begin
          byte_cnt_d = '0;
          case (rx_shift_q)
            CMD_FREQ, CMD_PERIOD: begin
              cmd_sh_d    = rx_shift_q;
              dec_state_d = D_PAYLOAD;
            end
            CMD_DATA, CMD_CTRL, CMD_REPEAT: begin
              cmd_sh_d    = rx_shift_q;
              dec_state_d = D_CHAN;
            end
            default: dec_state_d = D_IDLE;
          endcase
        end
      end
      D_CHAN: begin
        if (rx_done) begin
          chan_sh_d   = rx_shift_q;
          dec_state_d = D_PAYLOAD;
        end
      end
      D_PAYLOAD: begin
        if (rx_done) begin
          data_sh_d = {rx_shift_q, data_sh_q[DATA_BIT-1:8]};
          if (byte_cnt_q == byte_last) dec_state_d = D_COMMIT;
          else                         byte_cnt_d  = byte_cnt_q + BC_W'(1);
        end
      end
      D_COMMIT: begin
        done_tick_o = 1'b1;
        cmd_d       = cmd_sh_q;
        dec_state_d = D_IDLE;
        case (cmd_sh_q)
          CMD_FREQ: freq_pat_d = data_sh_q;
          CMD_PERIOD: begin
            slow_d = data_sh_q[DATA_BIT-8*FREQ_NUM +: 8];
            fast_d = data_sh_q[DATA_BIT-8 +: 8];
          end
          CMD_DATA: begin
            sel_d     = chan_sh_q;
            out_pat_d = data_sh_q;
          end
          CMD_CTRL: begin
            sel_d  = chan_sh_q;
            en_d   = data_sh_q[DATA_BIT-8];
            mode_d = data_sh_q[DATA_BIT-7 +: 2];
            stop_d = data_sh_q[DATA_BIT-5];
          end
          CMD_REPEAT: begin
            sel_d = chan_sh_q;
            rep_d = data_sh_q[DATA_BIT-8 +: 8];
          end
          default: cmd_d = cmd_sh_q;
        endcase
      end
      default: dec_state_d = D_IDLE;
    endcase
  end

  assign output_pattern_o = out_pat_q;
  assign freq_pattern_o   = freq_pat_q;
  assign sel_out_o        = sel_q;
  assign mode_o           = mode_q;
  assign enable_o         = en_q;
  assign stop_o           = stop_q;
  assign slow_period_o    = slow_q;
  assign fast_period_o    = fast_q;
  assign repeat_o         = rep_q;
  assign cmd_o            = cmd_q;

  // ---------------- Echo transmitter ----------------
`ifdef UART_CMD_ECHO_EN
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

  tx_state_t        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic [9:0]       tx_frame_q, tx_frame_d;

  // Transmitter state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_frame_q <= '1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_frame_q <= tx_frame_d;
    end
  end

  // Transmitter next state; a byte arriving while busy is not queued
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_frame_d = tx_frame_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (rx_done) begin
          tx_frame_d = {1'b1, rx_shift_q, 1'b0};
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_frame_d = {1'b1, tx_frame_q[9:1]};
          if (tx_bit_q == 4'd9) tx_state_d = TX_IDLE;
          else                  tx_bit_d   = tx_bit_q + 4'd1;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign tx_o = (tx_state_q == TX_BUSY) ? tx_frame_q[0] : 1'b1;
`else
  assign tx_o = 1'b1;
`endif

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb/tb_uart_cmd_decoder.sv - scoreboard bench for uart_cmd_decoder with a frame-level reference model
module tb_uart_cmd_decoder;

  localparam int SYS_CLK = 1_000_000;
  localparam int BAUD    = 62_500;
  localparam int CPB     = SYS_CLK / BAUD;
  localparam int H       = CPB / 2;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        rx_i = 1'b1;
  logic        tx_o;
  logic [31:0] output_pattern_o, freq_pattern_o;
  logic [7:0]  sel_out_o, slow_period_o, fast_period_o, repeat_o, cmd_o;
  logic [1:0]  mode_o;
  logic        enable_o, stop_o, done_tick_o;

  uart_cmd_decoder #(
    .SYS_CLK(SYS_CLK), .BAUD_RATE(BAUD), .DATA_BIT(32), .PACK_NUM(4), .FREQ_NUM(2)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .rx_i(rx_i), .tx_o(tx_o),
    .output_pattern_o(output_pattern_o), .freq_pattern_o(freq_pattern_o),
    .sel_out_o(sel_out_o), .mode_o(mode_o), .enable_o(enable_o), .stop_o(stop_o),
    .slow_period_o(slow_period_o), .fast_period_o(fast_period_o),
    .repeat_o(repeat_o), .cmd_o(cmd_o), .done_tick_o(done_tick_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [31:0] outp;
    logic [31:0] freq;
    logic [7:0]  sel;
    logic [1:0]  mode;
    logic        en;
    logic        stop;
    logic [7:0]  slow;
    logic [7:0]  fast;
    logic [7:0]  rep;
  } obs_t;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         stop_start = 0;
  obs_t       cur;
  obs_t       exp_q[$];
  logic [7:0] frame[$];
  logic [7:0] echo_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t observe();
    obs_t o;
    o.cmd = cmd_o; o.outp = output_pattern_o; o.freq = freq_pattern_o;
    o.sel = sel_out_o; o.mode = mode_o; o.en = enable_o; o.stop = stop_o;
    o.slow = slow_period_o; o.fast = fast_period_o; o.rep = repeat_o;
    return o;
  endfunction

  function automatic int frame_len(input logic [7:0] c);
    case (c)
      8'h01: return 5;
      8'h02: return 3;
      8'h03: return 6;
      8'h04: return 3;
      8'h05: return 3;
      default: return 0;
    endcase
  endfunction

  // Reference model: collect whole frames, then apply their effect on the register image
  task automatic model_byte(input logic [7:0] b);
    echo_q.push_back(b);
    if (frame.size() == 0 && frame_len(b) == 0) return;
    frame.push_back(b);
    if (frame.size() == frame_len(frame[0])) begin
      case (frame[0])
        8'h01: cur.freq = {frame[4], frame[3], frame[2], frame[1]};
        8'h02: begin cur.slow = frame[1]; cur.fast = frame[2]; end
        8'h03: begin cur.sel = frame[1]; cur.outp = {frame[5], frame[4], frame[3], frame[2]}; end
        8'h04: begin
          cur.sel = frame[1]; cur.en = frame[2][0]; cur.mode = frame[2][2:1]; cur.stop = frame[2][3];
        end
        default: begin cur.sel = frame[1]; cur.rep = frame[2]; end
      endcase
      cur.cmd = frame[0];
      exp_q.push_back(cur);
      frame.delete();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    @(negedge clk);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    stop_start = cyc;
    if (good_stop) model_byte(b);
    rx_i = good_stop;
    repeat (CPB) @(negedge clk);
    rx_i = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [39:0] pay);
    send_byte(c, 1'b1);
    for (int i = 0; i < frame_len(c) - 1; i++) send_byte(pay[8*i +: 8], 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    cur = '0;
    frame.delete();
    echo_q.delete();
    @(negedge clk);
    vectors++;
    if (observe() !== obs_t'(0) || tx_o !== 1'b1 || done_tick_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got %h tx=%b tick=%b expected all zero, tx=1", observe(), tx_o, done_tick_o);
    end
  endtask

  // Monitor: on each commit pulse check latency, pulse width and the full register image
  initial begin
    obs_t act, e;
    int   lat;
    forever begin
      @(negedge clk);
      if (done_tick_o === 1'b1) begin
        lat = cyc - stop_start;
        vectors++;
        if (lat < H + 1 || lat > H + 5) begin
          miscompares++;
          $display("FAIL done_latency: got %0d cycles after stop start, expected %0d..%0d", lat, H + 1, H + 5);
        end
        @(negedge clk);
        vectors++;
        if (done_tick_o !== 1'b0) begin
          miscompares++;
          $display("FAIL done_width: got tick=%b in second cycle, expected 0", done_tick_o);
        end
        act = observe();
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_commit: got image %h, expected no commit", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            miscompares++;
            $display("FAIL frame_outputs: got %h expected %h", act, e);
          end
        end
`ifndef UART_CMD_ECHO_EN
        vectors++;
        if (tx_o !== 1'b1) begin
          miscompares++;
          $display("FAIL tx_idle: got %b expected 1", tx_o);
        end
`endif
      end
    end
  end

`ifdef UART_CMD_ECHO_EN
  // Echo monitor: decode each transmitted 8N1 byte at bit mid-points
  initial begin
    logic [7:0] b;
    logic       sb;
    forever begin
      @(negedge clk);
      if (rst_i === 1'b0 && tx_o === 1'b0) begin
        repeat (H) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx_o;
        end
        repeat (CPB) @(negedge clk);
        sb = tx_o;
        vectors++;
        if (echo_q.size() == 0) begin
          miscompares++;
          $display("FAIL echo_unexpected: got %h expected none", b);
        end else if (b !== echo_q[0] || sb !== 1'b1) begin
          miscompares++;
          $display("FAIL echo_byte: got %h stop=%b expected %h stop=1", b, sb, echo_q[0]);
          void'(echo_q.pop_front());
        end else begin
          void'(echo_q.pop_front());
        end
      end
    end
  end
`endif

  initial begin
    logic [7:0] c;
    logic [39:0] pay;
    int t;
    cur = '0;
    do_reset();

    send_frame(8'h02, 40'h05_14);
    repeat (4) @(negedge clk);
    vectors++;
    if (slow_period_o !== 8'h14 || fast_period_o !== 8'h05 || cmd_o !== 8'h02) begin
      miscompares++;
      $display("FAIL period_direct: got slow=%h fast=%h cmd=%h expected 14 05 02",
               slow_period_o, fast_period_o, cmd_o);
    end
    send_frame(8'h01, 40'h11_22_33_44);
    send_frame(8'h03, 40'hBB_CC_DD_EE_05);
    send_frame(8'h05, 40'h03_05);
    send_frame(8'h04, 40'h03_05);

    send_byte(8'h02, 1'b0);
    send_byte(8'h7F, 1'b1);
    send_frame(8'h02, 40'h55_AA);

    send_byte(8'h03, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'hEE, 1'b1);
    repeat (12 * CPB) @(negedge clk);
    do_reset();
    send_frame(8'h04, 40'h0B_07);

    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(6, 255)), 1'b1);
      if ($urandom_range(0, 4) == 0) send_byte(8'($urandom), 1'b0);
      c = 8'($urandom_range(1, 5));
      pay = {$urandom, $urandom};
      send_frame(c, pay);
    end

    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (12 * CPB) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_commits: got %0d pending expected 0", exp_q.size());
    end
`ifdef UART_CMD_ECHO_EN
    vectors++;
    if (echo_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_echo: got %0d pending expected 0", echo_q.size());
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Host-command front end for the multi-frequency serial-output generator. It contains three parts:
  - an 8N1 UART receiver;
  - a command-frame decoder that turns received bytes into pattern, period, repeat and control registers for the output channels;
  - a UART transmitter that echoes received bytes (optional).
- Sits between the board UART pins and the channel output engines.

Parameters:
- SYS_CLK, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, UART bit rate; CLKS_PER_BIT = SYS_CLK/BAUD_RATE (integer division).
- DATA_BIT, 32, width of the data and frequency patterns.
- PACK_NUM, 4, payload bytes per pattern (DATA_BIT/8).
- FREQ_NUM, 2, payload bytes in a PERIOD frame (slow, fast).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- rx_i  in  1  UART serial input, idle high.
- tx_o  out  1  UART serial output, idle high.
- output_pattern_o  out  DATA_BIT  data pattern for the selected channel.
- freq_pattern_o  out  DATA_BIT  per-bit slow/fast frequency select pattern.
- sel_out_o  out  8  channel index of the last channel frame.
- mode_o  out  2  0 one-shot, 1 continuous, 2 repeat.
- enable_o  out  1  channel enable.
- stop_o  out  1  channel stop request.
- slow_period_o  out  8  slow bit period.
- fast_period_o  out  8  fast bit period.
- repeat_o  out  8  repeat count.
- cmd_o  out  8  command of the last completed frame.
- done_tick_o  out  1  one-cycle pulse: frame committed.

Behaviour:
- Reset:
  - All register outputs are 0; tx_o is 1; FSMs go to IDLE.
  - Reset mid-frame discards any partial frame.
- UART RX (8N1, LSB first):
  - A falling edge on rx_i (2-flop synchronised) starts reception.
  - At CLKS_PER_BIT/2 the line is re-checked. If it is high, this is a false start: return to idle.
  - Data bits are sampled every CLKS_PER_BIT after that.
  - Stop bit sampled at its mid-point:
    - If 1, rx_done (internal) pulses for one cycle with the byte.
    - If 0, the byte is dropped silently.
- Command codes:
  - CMD_FREQ=8'h01, CMD_PERIOD=8'h02, CMD_DATA=8'h03, CMD_CTRL=8'h04, CMD_REPEAT=8'h05.
- Frame formats (bytes in order):
  - FREQ: cmd, PACK_NUM bytes LSB first.
  - PERIOD: cmd, slow, fast.
  - DATA: cmd, channel, PACK_NUM bytes LSB first.
  - CTRL: cmd, channel, ctrl byte {4'h0, stop, mode[1:0], en}.
  - REPEAT: cmd, channel, count.
- Decoder FSM:
  - IDLE: on a byte matching a valid cmd, latch it. Go to CHAN for DATA/CTRL/REPEAT, or PAYLOAD for FREQ/PERIOD. An unknown byte is ignored, with no pulse.
  - CHAN: latch the next byte as the channel into a shadow register, then go to PAYLOAD.
  - PAYLOAD: shift bytes into a shadow register; the byte counter terminates at PACK_NUM, FREQ_NUM or 1 according to cmd.
  - COMMIT: one cycle. Copy the shadow registers to the outputs that frame affects, set cmd_o, pulse done_tick_o, then go to IDLE.
  - Other outputs hold their values. Outputs change only at COMMIT, atomically.
- Latency:
  - The COMMIT cycle is the clock after the rx_done of the final byte.
  - done_tick_o is high for exactly that one cycle.
- There is no inter-byte timeout; a partial frame waits indefinitely.
- sel_out_o updates only on DATA/CTRL/REPEAT commits.

Optional Feature:
- Macro UART_CMD_ECHO_EN.
- Defined:
  - Each valid received byte starts the 8N1 transmitter (start, 8 data LSB first, stop, each CLKS_PER_BIT long).
  - A start request arriving while the transmitter is busy is dropped.
- Undefined: the transmitter is not built and tx_o is tied to 1.

Test Plan:
- PERIOD frame 02 14 05 -> slow_period_o=0x14, fast_period_o=0x05, cmd_o=0x02, one done_tick_o pulse; all other outputs unchanged.
- FREQ frame 01 44 33 22 11 -> freq_pattern_o=0x11223344, done_tick_o pulses once, one clock after the last stop-bit sample.
- DATA 03 05 EE DD CC BB, then REPEAT 05 05 03 -> output_pattern_o=0xBBCCDDEE, sel_out_o=5, repeat_o=3.
- CTRL 04 05 03 -> mode_o=01, enable_o=1, stop_o=0, cmd_o=0x04; with UART_CMD_ECHO_EN, tx_o reproduces bytes 04 05 03.
- Byte with stop bit 0, and an unknown command 0x7F -> no done_tick_o; the next valid frame decodes correctly.
- rst_i asserted after 03 05 EE -> all outputs 0, FSM IDLE; the following complete frame decodes normally.
